// File: rtl/fp_ext_pipe_if.sv
// Handshake and payload bundle for fp_ext_pipe: operand pair in, extended/classified pair out.
interface fp_ext_pipe_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] data1;
   logic [31:0] data2;
   logic [1:0]  fmt;
   logic [2:0]  rm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data1;
   logic [31:0] out_data2;
   logic [32:0] ext1;
   logic [32:0] ext2;
   logic [9:0]  class1;
   logic [9:0]  class2;
   logic [1:0]  out_fmt;
   logic [2:0]  out_rm;

   modport slave (
      input  in_valid, data1, data2, fmt, rm, out_ready,
      output in_ready, out_valid, out_data1, out_data2, ext1, ext2,
             class1, class2, out_fmt, out_rm
   );

   modport master (
      output in_valid, data1, data2, fmt, rm, out_ready,
      input  in_ready, out_valid, out_data1, out_data2, ext1, ext2,
             class1, class2, out_fmt, out_rm
   );
endinterface

// File: rtl/fp_ext_pipe.sv
// binary32 operand extension + fclass stage feeding the FP min/max unit.
// Optional macro FP_EXT_DAZ_EN: denormals-are-zero (subnormals reported as signed zero, no LZC).
module fp_ext_pipe #(
   parameter int PIPE = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   fp_ext_pipe_if.slave bus
);

   typedef struct packed {
      logic [31:0] data1;
      logic [31:0] data2;
      logic [9:0]  class1;
      logic [9:0]  class2;
      logic [1:0]  fmt;
      logic [2:0]  rm;
   } s1_t;

   typedef struct packed {
      logic [31:0] data1;
      logic [31:0] data2;
      logic [32:0] ext1;
      logic [32:0] ext2;
      logic [9:0]  class1;
      logic [9:0]  class2;
      logic [1:0]  fmt;
      logic [2:0]  rm;
   } out_t;

   function automatic logic [9:0] fclass(input logic [31:0] x);
      logic [9:0] c;
      c = '0;
      if (x[30:23] == 8'hFF) begin
         if (x[22:0] == '0) c[x[31] ? 0 : 7] = 1'b1;
         else               c[x[22] ? 9 : 8] = 1'b1;
      end else if (x[30:23] == 8'h00) begin
`ifdef FP_EXT_DAZ_EN
         c[x[31] ? 3 : 4] = 1'b1;
`else
         if (x[22:0] == '0) c[x[31] ? 3 : 4] = 1'b1;
         else               c[x[31] ? 2 : 5] = 1'b1;
`endif
      end else begin
         c[x[31] ? 1 : 6] = 1'b1;
      end
      return c;
   endfunction

`ifndef FP_EXT_DAZ_EN
   function automatic logic [4:0] lzc23(input logic [22:0] m);
      logic       found;
      logic [4:0] n;
      found = 1'b0;
      n     = 5'd0;
      for (int i = 22; i >= 0; i--) begin
         if (m[i])        found = 1'b1;
         else if (!found) n = n + 5'd1;
      end
      return n;
   endfunction
`endif

   // Subnormals are renormalised below the smallest normal exponent (129) so
   // that ext[31:0] stays monotonic in magnitude across the normal/subnormal edge.
   function automatic logic [32:0] extend(input logic [31:0] x);
      logic [32:0] r;
`ifndef FP_EXT_DAZ_EN
      logic [4:0]  lz;
      logic [22:0] sh;
`endif
      r = {x[31], 32'h0};
      if (x[30:23] == 8'hFF) begin
         r = {x[31], 9'd383, x[22:0]};
      end else if (x[30:23] != 8'h00) begin
         r = {x[31], {1'b0, x[30:23]} + 9'd128, x[22:0]};
`ifndef FP_EXT_DAZ_EN
      end else if (x[22:0] != '0) begin
         lz = lzc23(x[22:0]);
         sh = x[22:0] << lz;
         r  = {x[31], 9'd128 - {4'd0, lz}, sh[21:0], 1'b0};
`endif
      end
      return r;
   endfunction

   function automatic s1_t classify_pair(input logic [31:0] d1, input logic [31:0] d2,
                                         input logic [1:0] f, input logic [2:0] r);
      s1_t p;
      p.data1  = d1;
      p.data2  = d2;
      p.class1 = fclass(d1);
      p.class2 = fclass(d2);
      p.fmt    = f;
      p.rm     = r;
      return p;
   endfunction

   function automatic out_t normalise_pair(input s1_t p);
      out_t o;
      o.data1  = p.data1;
      o.data2  = p.data2;
      o.ext1   = extend(p.data1);
      o.ext2   = extend(p.data2);
      o.class1 = p.class1;
      o.class2 = p.class2;
      o.fmt    = p.fmt;
      o.rm     = p.rm;
      return o;
   endfunction

   logic out_valid_q, out_valid_d;
   out_t out_q, out_d;
   logic out_load;
   s1_t  in_pkt;

   assign out_load = !out_valid_q | bus.out_ready;
   assign in_pkt   = classify_pair(bus.data1, bus.data2, bus.fmt, bus.rm);

   generate
      if (PIPE == 1) begin : g_one
         logic in_fire;
         assign bus.in_ready = out_load;
         assign in_fire      = bus.in_valid & out_load;

         // NOTE: defaults first so every path assigns every output; no latches.
         always_comb begin
            out_valid_d = out_valid_q;
            out_d       = out_q;
            if (out_load) out_valid_d = in_fire;
            if (in_fire)  out_d       = normalise_pair(in_pkt);
            if (clear)    out_valid_d = 1'b0;
         end
      end else begin : g_two
         logic s1_valid_q, s1_valid_d;
         s1_t  s1_q, s1_d;
         logic s1_advance, in_ready_w, in_fire;

         assign s1_advance   = s1_valid_q & out_load;
         assign in_ready_w   = !s1_valid_q | s1_advance;
         assign in_fire      = bus.in_valid & in_ready_w;
         assign bus.in_ready = in_ready_w;

         always_comb begin
            s1_valid_d  = s1_valid_q;
            s1_d        = s1_q;
            out_valid_d = out_valid_q;
            out_d       = out_q;
            if (in_ready_w) s1_valid_d  = in_fire;
            if (in_fire)    s1_d        = in_pkt;
            if (out_load)   out_valid_d = s1_valid_q;
            if (s1_advance) out_d       = normalise_pair(s1_q);
            if (clear) begin
               s1_valid_d  = 1'b0;
               out_valid_d = 1'b0;
            end
         end

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               s1_valid_q <= 1'b0;
               s1_q       <= '0;
            end else begin
               s1_valid_q <= s1_valid_d;
               s1_q       <= s1_d;
            end
         end
      end
   endgenerate

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data1 = out_q.data1;
   assign bus.out_data2 = out_q.data2;
   assign bus.ext1      = out_q.ext1;
   assign bus.ext2      = out_q.ext2;
   assign bus.class1    = out_q.class1;
   assign bus.class2    = out_q.class2;
   assign bus.out_fmt   = out_q.fmt;
   assign bus.out_rm    = out_q.rm;

endmodule

// File: tb/tb_fp_ext_pipe.sv
// Self-checking bench for fp_ext_pipe: value-level model of the binary32 extension
// plus an occupancy/timing scoreboard, driven by directed and random traffic.
module tb_fp_ext_pipe;
   localparam int PIPE = 2;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic clear = 1'b0;

   fp_ext_pipe_if bus ();

   fp_ext_pipe #(.PIPE(PIPE)) dut (
      .clock (clock),
      .reset (reset),
      .clear (clear),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] d1;
      logic [31:0] d2;
      logic [1:0]  fmt;
      logic [2:0]  rm;
      int          a;
      int          arr;
   } ent_t;

   ent_t q[$];
   int   edge_n     = 0;
   int   last_leave = 0;
   int   n_tests    = 0;
   int   n_fail     = 0;
   logic last_fire;
   logic last_ready;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Value model: classify by IEEE field meaning.
   function automatic logic [9:0] m_class(input logic [31:0] x);
      logic [9:0] r;
      int idx;
      logic s;
      logic [7:0] e;
      logic [22:0] m;
      s = x[31]; e = x[30:23]; m = x[22:0];
      if (e == 8'd255)    idx = (m == 0) ? (s ? 0 : 7) : (m[22] ? 9 : 8);
      else if (e == 8'd0) begin
`ifdef FP_EXT_DAZ_EN
         idx = s ? 3 : 4;
`else
         idx = (m == 0) ? (s ? 3 : 4) : (s ? 2 : 5);
`endif
      end
      else idx = s ? 1 : 6;
      r = '0;
      r[idx] = 1'b1;
      return r;
   endfunction

   // Value model: a subnormal m*2^-149 with top set bit p has unbiased exponent p-149,
   // i.e. extended exponent 106+p; mantissa is the bits below that leading one.
   function automatic logic [32:0] m_ext(input logic [31:0] x);
      logic s;
      int e, p;
      logic [63:0] mm;
      s = x[31];
      e = int'(x[30:23]);
      if (e == 255) return {s, 9'd383, x[22:0]};
      if (e != 0)   return {s, 9'(e + 128), x[22:0]};
`ifdef FP_EXT_DAZ_EN
      return {s, 32'h0};
`else
      if (x[22:0] == 0) return {s, 32'h0};
      p = 0;
      for (int i = 0; i < 23; i++) if (x[i]) p = i;
      mm = (64'(x[22:0]) << (23 - p)) & 64'h7F_FFFF;
      return {s, 9'(106 + p), mm[22:0]};
`endif
   endfunction

   function automatic logic [159:0] exp_payload(input ent_t e);
      return {5'd0, e.d1, e.d2, m_ext(e.d1), m_ext(e.d2), m_class(e.d1), m_class(e.d2), e.fmt, e.rm};
   endfunction

   function automatic logic [159:0] dut_payload();
      return {5'd0, bus.out_data1, bus.out_data2, bus.ext1, bus.ext2, bus.class1, bus.class2,
              bus.out_fmt, bus.out_rm};
   endfunction

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // One clock: inputs already driven at the negedge; compare, then advance the model.
   task automatic cycle();
      logic exp_valid, exp_ready, acc, fire;
      ent_t e;
      #1;
      exp_valid = (q.size() > 0) && (q[0].arr <= edge_n);
      exp_ready = (q.size() < PIPE) || (exp_valid && bus.out_ready);
      check("out_valid", bus.out_valid, exp_valid);
      check("in_ready", bus.in_ready, exp_ready);
      last_ready = bus.in_ready;
      if (exp_valid) begin
         check("payload", dut_payload(), exp_payload(q[0]));
`ifndef FP_EXT_DAZ_EN
         if (q[0].d1[31] == q[0].d2[31] && q[0].d1[30:23] != 8'hFF && q[0].d2[30:23] != 8'hFF)
            check("order", bus.ext1[31:0] < bus.ext2[31:0], q[0].d1[30:0] < q[0].d2[30:0]);
`endif
      end
      acc  = exp_valid && bus.out_ready;
      fire = bus.in_valid && exp_ready && !clear;
      @(posedge clock);
      edge_n++;
      if (clear) begin
         q.delete();
      end else begin
         if (acc) begin
            void'(q.pop_front());
            last_leave = edge_n;
            if (q.size() > 0) q[0].arr = imax(q[0].a + PIPE - 1, last_leave);
         end
         if (fire) begin
            e.d1 = bus.data1; e.d2 = bus.data2; e.fmt = bus.fmt; e.rm = bus.rm;
            e.a = edge_n;
            e.arr = imax(edge_n + PIPE - 1, last_leave);
            q.push_back(e);
         end
      end
      last_fire = fire;
      @(negedge clock);
   endtask

   function automatic logic [31:0] rand_fp();
      logic [31:0] x;
      logic [22:0] m;
      x = $urandom;
      case ($urandom_range(0, 5))
         0: x[30:0] = '0;
         1: begin
            m = 23'($urandom) >> $urandom_range(0, 22);
            if (m == 0) m = 23'd1;
            x[30:0] = {8'h00, m};
         end
         4: x[30:0] = {8'hFF, 23'h0};
         5: begin
            x[30:23] = 8'hFF;
            if (x[22:0] == 0) x[0] = 1'b1;
         end
         default: if (x[30:23] == 8'h00 || x[30:23] == 8'hFF) x[30:23] = 8'h80;
      endcase
      return x;
   endfunction

   // Directed pair with literal expectations for both the model and the DUT.
   task automatic pin(input logic [31:0] d1, input logic [31:0] d2,
                      input logic [32:0] e1, input logic [9:0] c1,
                      input logic [32:0] e2, input logic [9:0] c2);
      int k;
      check("model_ext1", m_ext(d1), e1);
      check("model_cls1", m_class(d1), c1);
      check("model_ext2", m_ext(d2), e2);
      check("model_cls2", m_class(d2), c2);
      bus.data1 = d1; bus.data2 = d2; bus.fmt = 2'd1; bus.rm = 3'd2;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      cycle();
      bus.in_valid = 1'b0;
      k = 0;
      while (!bus.out_valid && k < 20) begin
         cycle();
         k++;
      end
      check("pin_latency", k, PIPE - 1);
      check("pin_ext1", bus.ext1, e1);
      check("pin_cls1", bus.class1, c1);
      check("pin_ext2", bus.ext2, e2);
      check("pin_cls2", bus.class2, c2);
      check("pin_raw", {bus.out_data1, bus.out_data2}, {d1, d2});
      cycle();
   endtask

   logic [31:0] burst [4];
   int bi, low_seen;

   initial begin
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      bus.data1 = '0; bus.data2 = '0; bus.fmt = '0; bus.rm = '0;
      #1;
      check("rst_valid", bus.out_valid, 1'b0);
      check("rst_ready", bus.in_ready, 1'b1);
      check("rst_payload", dut_payload(), '0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;

      pin(32'h3F80_0000, 32'h8000_0000, 33'h0_7F80_0000, 10'h040, 33'h1_0000_0000, 10'h008);
`ifdef FP_EXT_DAZ_EN
      pin(32'h0000_0001, 32'h0040_0000, 33'h0, 10'h010, 33'h0, 10'h010);
`else
      pin(32'h0000_0001, 32'h0040_0000, 33'h0_3500_0000, 10'h020, 33'h0_4000_0000, 10'h020);
`endif

      // Burst of four with a three-cycle downstream stall.
      for (int i = 0; i < 4; i++) burst[i] = rand_fp();
      bi = 0; low_seen = 0;
      for (int c = 0; c < 14; c++) begin
         bus.in_valid  = (bi < 4);
         bus.data1     = burst[bi % 4];
         bus.data2     = ~burst[bi % 4];
         bus.out_ready = !(c >= 2 && c < 5);
         cycle();
         if (!last_ready) low_seen++;
         if (last_fire) bi++;
      end
      check("burst_sent", bi, 4);
      check("burst_ready_low", low_seen > 0, 1'b1);
      check("burst_drained", q.size(), 0);

      // clear with entries in flight and a transfer attempted in the same cycle.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.in_valid = 1'b1; bus.data1 = rand_fp(); bus.data2 = rand_fp();
         cycle();
      end
      clear = 1'b1;
      bus.data1 = rand_fp();
      cycle();
      clear = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      check("clear_valid", bus.out_valid, 1'b0);
      pin(32'h7F80_0001, 32'h7FC0_0000, 33'h0_BF80_0001, 10'h100, 33'h0_BFC0_0000, 10'h200);

      // Asynchronous reset with two entries in flight.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.in_valid = 1'b1; bus.data1 = rand_fp(); bus.data2 = rand_fp();
         cycle();
      end
      bus.in_valid = 1'b0;
      reset = 1'b0;
      #1;
      check("mid_rst_valid", bus.out_valid, 1'b0);
      check("mid_rst_ready", bus.in_ready, 1'b1);
      check("mid_rst_payload", dut_payload(), '0);
      q.delete();
      @(posedge clock);
      edge_n++;
      @(negedge clock);
      reset = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) cycle();

      // Random traffic.
      for (int c = 0; c < 600; c++) begin
         bus.in_valid  = $urandom_range(0, 9) < 7;
         bus.data1     = rand_fp();
         bus.data2     = ($urandom_range(0, 3) == 0) ? {bus.data1[31], rand_fp() & 32'h7FFF_FFFF} : rand_fp();
         bus.fmt       = 2'($urandom);
         bus.rm        = 3'($urandom);
         bus.out_ready = $urandom_range(0, 9) < 7;
         clear         = $urandom_range(0, 40) == 0;
         cycle();
      end
      clear = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      for (int i = 0; i < 2 * PIPE + 2; i++) cycle();
      check("final_drain", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fp_ext_pipe.md
Name:
fp_ext_pipe

Overview:
Pipelined operand-extension and classification stage directly upstream of the FP min/max unit. Takes two raw binary32 operands and produces:
- a 33-bit magnitude-ordered extended form per operand: sign, 9-bit exponent, normalised 23-bit mantissa.
- a 10-bit RISC-V fclass vector per operand.
- fmt/rm passed through unchanged.
Valid/ready handshake on both sides; the downstream min/max stage is combinational on these outputs.

Parameters:
PIPE, 2, pipeline depth; 1 = classify+normalise in one registered stage, 2 = classify in S1 and LZC/normalise in S2.

Ports:
reset  input  1  asynchronous active-low reset
clock  input  1  clock
clear  input  1  synchronous flush; drops all in-flight entries
in_valid  input  1  operand pair valid
in_ready  output  1  stage can accept
data1  input  32  operand 1, raw binary32
data2  input  32  operand 2, raw binary32
fmt  input  2  format tag, passthrough
rm  input  3  rounding/op select, passthrough
out_valid  output  1  result valid
out_ready  input  1  downstream accepts
out_data1  output  32  registered copy of data1
out_data2  output  32  registered copy of data2
ext1  output  33  extended operand 1
ext2  output  33  extended operand 2
class1  output  10  fclass of operand 1
class2  output  10  fclass of operand 2
out_fmt  output  2  fmt passthrough
out_rm  output  3  rm passthrough

Behaviour:
- Reset (reset==0, async): all valid flags 0; every data output, ext, class, out_fmt, out_rm = 0; in_ready = 1 after reset release.
- Transfer occurs when valid & ready are both high on a rising clock edge.
- Latency = PIPE cycles from input transfer to out_valid, with no stall.
- Full throughput: one pair per cycle.
- Each stage register loads when it is empty or when its downstream consumer takes its contents that cycle.
- in_ready = !s1_valid | s1_advance, where s1_advance = S1 moves on that cycle. The ready path is combinational; no skid buffer is required.
- Data is held stable while out_valid & !out_ready.
- clear: all valid flags are cleared next edge and the payload is don't-care. An input that would transfer in the same cycle as clear is dropped. Reset overrides clear.
- Class bits: 0 -inf, 1 -normal, 2 -subnormal, 3 -0, 4 +0, 5 +subnormal, 6 +normal, 7 +inf, 8 sNaN, 9 qNaN. Exactly one bit is set for a valid entry.
- ext[32] = sign. ext[31:23] = exp9. ext[22:0] = mantissa.
  - normal: exp9 = e+128, mant = m.
  - subnormal: lz = leading zeros of 23-bit m (0..22); exp9 = 128-lz; mant = (m << (lz+1))[22:0].
  - zero: exp9 = 0, mant = 0.
  - inf/NaN: exp9 = 383, mant = m unchanged.
- Ordering guarantee: for equal signs, unsigned comparison of ext[31:0] orders magnitudes exactly, including subnormals.
- NaNs are never quieted or canonicalised here; that is done downstream.
- The LZC is 23-bit priority logic. With PIPE=2 it resides wholly in S2; S1 registers e, m, sign and class.

Optional Feature:
FP_EXT_DAZ_EN:
- Defined: denormals-are-zero. A subnormal input is reported as signed zero (class bit 3 or 4) with ext = {sign, 32'h0}. out_data keeps the raw input. The S2 LZC is removed.
- Undefined: full subnormal handling as above.

Test Plan:
- Reset mid-stream with 2 entries in flight, reset low 1 cycle -> out_valid = 0, all outputs 0, in_ready = 1; the entries never emerge.
- data1=0x3F800000, data2=0x80000000, out_ready=1, PIPE=2 -> after 2 cycles:
  - ext1=0x07F800000, class1=0x040
  - ext2=0x100000000, class2=0x008
- data1=0x00000001, data2=0x00400000 -> ext1=0x035000000, class1=0x020; ext2=0x040000000, class2=0x020.
  - With FP_EXT_DAZ_EN: ext1=ext2=0, class=0x010.
- data1=0x7F800001, data2=0x7FC00000 -> ext1=0x0BF800001, class1=0x100; ext2=0x0BFC00000, class2=0x200; out_data unchanged.
- Back-to-back 4 pairs, out_ready low for 3 cycles mid-burst -> no loss or duplication, order preserved, in_ready drops once both stages are full, outputs stable while stalled.
- clear asserted with 2 in flight plus in_valid high -> next cycle out_valid = 0; following pair emerges normally after PIPE cycles.
